// File: rtl/br_rs_if.sv
// ---------------------------------------------------------------------------
// br_rs_if
// Bundles every signal the branch reservation station exchanges with its
// surroundings, apart from clk/rst:
//   flush                 backend flush, clears the station
//   disp_*                dispatch handshake and uop payload from rename
//   cdb_*                 NUM_CDB snooped result broadcasts (tag + value)
//   br_rs_valid /
//   fu_br_ready /
//   fu_br_reg_in          issue handshake and uop towards the branch FU
// The slave modport is the station's view; master is the environment's.
// ---------------------------------------------------------------------------
interface br_rs_if #(
  parameter int ROB_IDX_W = 5,
  parameter int PRF_IDX_W = 6,
  parameter int NUM_CDB   = 2
);

  // Issued uop: the full dispatch payload plus the captured operand values.
  typedef struct packed {
    logic [3:0]           fu_opcode;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic                 predict_taken;
    logic [31:0]          predict_target;
    logic [ROB_IDX_W-1:0] rob_id;
    logic [4:0]           rd_arch;
    logic [PRF_IDX_W-1:0] rd_phy;
    logic [PRF_IDX_W-1:0] rs1_phy;
    logic [PRF_IDX_W-1:0] rs2_phy;
    logic [31:0]          rs1_value;
    logic [31:0]          rs2_value;
  } fu_br_reg_t;

  logic                         flush;

  logic                         disp_valid;
  logic                         disp_ready;
  logic [3:0]                   disp_fu_opcode;
  logic [31:0]                  disp_pc;
  logic [31:0]                  disp_imm;
  logic                         disp_predict_taken;
  logic [31:0]                  disp_predict_target;
  logic [ROB_IDX_W-1:0]         disp_rob_id;
  logic [4:0]                   disp_rd_arch;
  logic [PRF_IDX_W-1:0]         disp_rd_phy;
  logic [PRF_IDX_W-1:0]         disp_rs1_phy;
  logic [PRF_IDX_W-1:0]         disp_rs2_phy;
  logic                         disp_rs1_ready;
  logic                         disp_rs2_ready;
  logic [31:0]                  disp_rs1_value;
  logic [31:0]                  disp_rs2_value;

  logic [NUM_CDB-1:0]           cdb_valid;
  logic [NUM_CDB*PRF_IDX_W-1:0] cdb_rd_phy;
  logic [NUM_CDB*32-1:0]        cdb_rd_value;

  logic                         br_rs_valid;
  logic                         fu_br_ready;
  fu_br_reg_t                   fu_br_reg_in;

  modport master (
    output flush,
    output disp_valid, disp_fu_opcode, disp_pc, disp_imm, disp_predict_taken,
           disp_predict_target, disp_rob_id, disp_rd_arch, disp_rd_phy,
           disp_rs1_phy, disp_rs2_phy, disp_rs1_ready, disp_rs2_ready,
           disp_rs1_value, disp_rs2_value,
    output cdb_valid, cdb_rd_phy, cdb_rd_value,
    output fu_br_ready,
    input  disp_ready, br_rs_valid, fu_br_reg_in
  );

  modport slave (
    input  flush,
    input  disp_valid, disp_fu_opcode, disp_pc, disp_imm, disp_predict_taken,
           disp_predict_target, disp_rob_id, disp_rd_arch, disp_rd_phy,
           disp_rs1_phy, disp_rs2_phy, disp_rs1_ready, disp_rs2_ready,
           disp_rs1_value, disp_rs2_value,
    input  cdb_valid, cdb_rd_phy, cdb_rd_value,
    input  fu_br_ready,
    output disp_ready, br_rs_valid, fu_br_reg_in
  );

endinterface

// File: rtl/br_rs.sv
// ---------------------------------------------------------------------------
// br_rs -- branch reservation station
// Holds dispatched branch / jump / AUIPC uops until both source operands are
// known, snoops the CDB to capture late operands, and hands the oldest ready
// uop to the branch FU, one per cycle.
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   br_rs_if.slave: flush, dispatch handshake + payload, CDB snoop
//         ports, issue handshake (br_rs_valid / fu_br_ready / fu_br_reg_in)
// Storage is an age-ordered compacting queue: slot 0 is always the oldest
// uop and valid entries occupy slots 0..count-1.
// ---------------------------------------------------------------------------
module br_rs #(
  parameter int DEPTH     = 4,
  parameter int ROB_IDX_W = 5,
  parameter int PRF_IDX_W = 6,
  parameter int NUM_CDB   = 2
) (
  input logic   clk,
  input logic   rst,
  br_rs_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Same layout as the interface's fu_br_reg_t so it can be driven out whole.
  typedef struct packed {
    logic [3:0]           fu_opcode;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic                 predict_taken;
    logic [31:0]          predict_target;
    logic [ROB_IDX_W-1:0] rob_id;
    logic [4:0]           rd_arch;
    logic [PRF_IDX_W-1:0] rd_phy;
    logic [PRF_IDX_W-1:0] rs1_phy;
    logic [PRF_IDX_W-1:0] rs2_phy;
    logic [31:0]          rs1_value;
    logic [31:0]          rs2_value;
  } pay_t;

  typedef struct packed {
    logic valid;
    logic rs1_rdy;
    logic rs2_rdy;
    pay_t pay;
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  entry_t           woken [DEPTH+1];
  entry_t           new_entry;
  logic [DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0] shift_en;
  logic             sel_found;
  pay_t             sel_pay;
  logic             issue_fire;
  logic             disp_fire;
  logic [CNT_W-1:0] wr_slot;

  // Looks a tag up on the CDB. Ports are scanned from the highest index down
  // so the lowest matching port is the one that sticks. Tag 0 is x0 and is
  // never woken by a broadcast.
  function automatic logic cdb_match(
    input  logic [PRF_IDX_W-1:0]         tag,
    input  logic [NUM_CDB-1:0]           vld,
    input  logic [NUM_CDB*PRF_IDX_W-1:0] tags,
    input  logic [NUM_CDB*32-1:0]        vals,
    output logic [31:0]                  val
  );
    logic hit;
    hit = 1'b0;
    val = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (vld[p] && (tag != '0) && (tags[p*PRF_IDX_W +: PRF_IDX_W] == tag)) begin
        hit = 1'b1;
        val = vals[p*32 +: 32];
      end
    end
    return hit;
  endfunction

  // Wakeup: every stored entry waiting on a source checks the CDB this cycle.
  // The result is what the entry will look like after the edge; the extra
  // top slot is an always-empty entry that gets shifted in on an issue.
  always_comb begin
    logic        hit1;
    logic        hit2;
    logic [31:0] v1;
    logic [31:0] v2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    v1   = '0;
    v2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = entry_q[i];
      hit1 = cdb_match(entry_q[i].pay.rs1_phy, bus.cdb_valid, bus.cdb_rd_phy,
                       bus.cdb_rd_value, v1);
      hit2 = cdb_match(entry_q[i].pay.rs2_phy, bus.cdb_valid, bus.cdb_rd_phy,
                       bus.cdb_rd_value, v2);
      if (entry_q[i].valid && !entry_q[i].rs1_rdy && hit1) begin
        woken[i].rs1_rdy       = 1'b1;
        woken[i].pay.rs1_value = v1;
      end
      if (entry_q[i].valid && !entry_q[i].rs2_rdy && hit2) begin
        woken[i].rs2_rdy       = 1'b1;
        woken[i].pay.rs2_value = v2;
      end
    end
    woken[DEPTH] = '0;
  end

  // Select the oldest entry whose operands were already captured (not the
  // ones being woken right now; those become issuable next cycle). Every
  // slot at or above the selected one shifts down when the issue fires.
  always_comb begin
    logic seen;
    sel_found = 1'b0;
    sel_oh    = '0;
    sel_pay   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && entry_q[i].valid && entry_q[i].rs1_rdy && entry_q[i].rs2_rdy) begin
        sel_found = 1'b1;
        sel_oh[i] = 1'b1;
        sel_pay   = entry_q[i].pay;
      end
    end
    issue_fire = !bus.flush && sel_found && bus.fu_br_ready;
    disp_fire  = bus.disp_valid && (count_q != CNT_W'(DEPTH)) && !bus.flush;
    seen     = 1'b0;
    shift_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      seen        = seen | sel_oh[i];
      shift_en[i] = issue_fire & seen;
    end
  end

  // Build the incoming entry. A source not ready at dispatch can still be
  // caught by a broadcast in the very same cycle.
  always_comb begin
    logic        hit1;
    logic        hit2;
    logic [31:0] v1;
    logic [31:0] v2;
    hit1 = cdb_match(bus.disp_rs1_phy, bus.cdb_valid, bus.cdb_rd_phy, bus.cdb_rd_value, v1);
    hit2 = cdb_match(bus.disp_rs2_phy, bus.cdb_valid, bus.cdb_rd_phy, bus.cdb_rd_value, v2);
    new_entry                    = '0;
    new_entry.valid              = 1'b1;
    new_entry.pay.fu_opcode      = bus.disp_fu_opcode;
    new_entry.pay.pc             = bus.disp_pc;
    new_entry.pay.imm            = bus.disp_imm;
    new_entry.pay.predict_taken  = bus.disp_predict_taken;
    new_entry.pay.predict_target = bus.disp_predict_target;
    new_entry.pay.rob_id         = bus.disp_rob_id;
    new_entry.pay.rd_arch        = bus.disp_rd_arch;
    new_entry.pay.rd_phy         = bus.disp_rd_phy;
    new_entry.pay.rs1_phy        = bus.disp_rs1_phy;
    new_entry.pay.rs2_phy        = bus.disp_rs2_phy;
    if (bus.disp_rs1_ready) begin
      new_entry.rs1_rdy       = 1'b1;
      new_entry.pay.rs1_value = bus.disp_rs1_value;
    end else if (hit1) begin
      new_entry.rs1_rdy       = 1'b1;
      new_entry.pay.rs1_value = v1;
    end
    if (bus.disp_rs2_ready) begin
      new_entry.rs2_rdy       = 1'b1;
      new_entry.pay.rs2_value = bus.disp_rs2_value;
    end else if (hit2) begin
      new_entry.rs2_rdy       = 1'b1;
      new_entry.pay.rs2_value = v2;
    end
  end

  // Next queue contents: compact over the issued slot (carrying wakeups
  // along), then drop the new uop into the first free slot after compaction.
  // A flush wipes everything, including a dispatch in the same cycle.
  always_comb begin
    wr_slot = count_q - CNT_W'(issue_fire);
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = shift_en[i] ? woken[i+1] : woken[i];
      if (disp_fire && (wr_slot == CNT_W'(i))) begin
        entry_d[i] = new_entry;
      end
      if (bus.flush) begin
        entry_d[i] = '0;
      end
    end
    if (bus.flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Full is judged on the stored count only, so an issue in the same cycle
  // never opens a slot for dispatch early.
  assign bus.disp_ready   = (count_q != CNT_W'(DEPTH));
  assign bus.br_rs_valid  = !bus.flush && sel_found;
  assign bus.fu_br_reg_in = sel_pay;

endmodule

// File: tb/tb_br_rs.sv
// ---------------------------------------------------------------------------
// tb_br_rs
// Directed bench for br_rs. A queue-based model of the station (oldest
// first, wake on CDB, remove first ready uop on issue) predicts the outputs;
// a negedge process compares the DUT with it every cycle, and the directed
// script also pins specific outputs to hand-computed values.
// ---------------------------------------------------------------------------
module tb_br_rs;

  localparam int DEPTH     = 4;
  localparam int ROB_IDX_W = 5;
  localparam int PRF_IDX_W = 6;
  localparam int NUM_CDB   = 2;

  localparam logic [3:0] OP_BEQ   = 4'd0;
  localparam logic [3:0] OP_BNE   = 4'd1;
  localparam logic [3:0] OP_BLT   = 4'd2;
  localparam logic [3:0] OP_BGE   = 4'd3;
  localparam logic [3:0] OP_JALR  = 4'd7;
  localparam logic [3:0] OP_AUIPC = 4'd8;

  typedef struct packed {
    logic [3:0]           fu_opcode;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic                 predict_taken;
    logic [31:0]          predict_target;
    logic [ROB_IDX_W-1:0] rob_id;
    logic [4:0]           rd_arch;
    logic [PRF_IDX_W-1:0] rd_phy;
    logic [PRF_IDX_W-1:0] rs1_phy;
    logic [PRF_IDX_W-1:0] rs2_phy;
    logic [31:0]          rs1_value;
    logic [31:0]          rs2_value;
  } pay_t;

  typedef struct {
    pay_t p;
    bit   r1;
    bit   r2;
  } muop_t;

  logic  clk;
  logic  rst;
  int    n_checks;
  int    n_fail;
  muop_t mq[$];

  br_rs_if #(.ROB_IDX_W(ROB_IDX_W), .PRF_IDX_W(PRF_IDX_W), .NUM_CDB(NUM_CDB)) bus ();

  br_rs #(.DEPTH(DEPTH), .ROB_IDX_W(ROB_IDX_W), .PRF_IDX_W(PRF_IDX_W), .NUM_CDB(NUM_CDB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First port carrying the tag wins; x0 never matches.
  function automatic bit model_cdb(input logic [PRF_IDX_W-1:0] tag, output logic [31:0] val);
    val = '0;
    if (tag == '0) return 1'b0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (bus.cdb_valid[p] && bus.cdb_rd_phy[p*PRF_IDX_W +: PRF_IDX_W] == tag) begin
        val = bus.cdb_rd_value[p*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int model_sel();
    foreach (mq[k]) begin
      if (mq[k].r1 && mq[k].r2) return k;
    end
    return -1;
  endfunction

  // Every cycle out of reset, the DUT must agree with the model.
  always @(negedge clk) begin
    int   s;
    bit   exp_valid;
    pay_t act;
    if (!rst) begin
      s = model_sel();
      exp_valid = !bus.flush && (s >= 0);
      checkOutput("cyc_br_rs_valid", 32'(bus.br_rs_valid), 32'(exp_valid));
      checkOutput("cyc_disp_ready", 32'(bus.disp_ready), 32'(mq.size() != DEPTH));
      if (exp_valid) begin
        act = bus.fu_br_reg_in;
        n_checks++;
        if (act !== mq[s].p) begin
          n_fail++;
          $display("[TB] FAIL cyc_payload: got %h, expected %h at %0t", act, mq[s].p, $time);
        end
      end
    end
  end

  // Advance the model at each edge from the inputs of the closing cycle.
  always @(posedge clk) begin
    int          s;
    bit          iss;
    bit          dsp;
    muop_t       m;
    logic [31:0] v;
    if (rst || bus.flush) begin
      mq.delete();
    end else begin
      s   = model_sel();
      iss = (s >= 0) && bus.fu_br_ready;
      dsp = bus.disp_valid && (mq.size() != DEPTH);
      foreach (mq[k]) begin
        m = mq[k];
        if (!m.r1 && model_cdb(m.p.rs1_phy, v)) begin
          m.r1 = 1'b1;
          m.p.rs1_value = v;
        end
        if (!m.r2 && model_cdb(m.p.rs2_phy, v)) begin
          m.r2 = 1'b1;
          m.p.rs2_value = v;
        end
        mq[k] = m;
      end
      if (iss) mq.delete(s);
      if (dsp) begin
        m.p.fu_opcode      = bus.disp_fu_opcode;
        m.p.pc             = bus.disp_pc;
        m.p.imm            = bus.disp_imm;
        m.p.predict_taken  = bus.disp_predict_taken;
        m.p.predict_target = bus.disp_predict_target;
        m.p.rob_id         = bus.disp_rob_id;
        m.p.rd_arch        = bus.disp_rd_arch;
        m.p.rd_phy         = bus.disp_rd_phy;
        m.p.rs1_phy        = bus.disp_rs1_phy;
        m.p.rs2_phy        = bus.disp_rs2_phy;
        m.r1 = bus.disp_rs1_ready;
        m.r2 = bus.disp_rs2_ready;
        m.p.rs1_value = bus.disp_rs1_ready ? bus.disp_rs1_value : 32'h0;
        m.p.rs2_value = bus.disp_rs2_ready ? bus.disp_rs2_value : 32'h0;
        if (!m.r1 && model_cdb(m.p.rs1_phy, v)) begin
          m.r1 = 1'b1;
          m.p.rs1_value = v;
        end
        if (!m.r2 && model_cdb(m.p.rs2_phy, v)) begin
          m.r2 = 1'b1;
          m.p.rs2_value = v;
        end
        mq.push_back(m);
      end
    end
  end

  // Present one dispatch uop; the other payload fields are derived from it.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm,
                               input int rob, input int t1, input bit r1, input logic [31:0] v1,
                               input int t2, input bit r2, input logic [31:0] v2);
    bus.disp_valid          = 1'b1;
    bus.disp_fu_opcode      = op;
    bus.disp_pc             = pc;
    bus.disp_imm            = imm;
    bus.disp_predict_taken  = rob[0];
    bus.disp_predict_target = pc + imm;
    bus.disp_rob_id         = ROB_IDX_W'(rob);
    bus.disp_rd_arch        = 5'(rob + 1);
    bus.disp_rd_phy         = PRF_IDX_W'(rob + 32);
    bus.disp_rs1_phy        = PRF_IDX_W'(t1);
    bus.disp_rs1_ready      = r1;
    bus.disp_rs1_value      = v1;
    bus.disp_rs2_phy        = PRF_IDX_W'(t2);
    bus.disp_rs2_ready      = r2;
    bus.disp_rs2_value      = v2;
  endtask

  task automatic setCdb(input int p, input int tag, input logic [31:0] val);
    bus.cdb_valid[p]                          = 1'b1;
    bus.cdb_rd_phy[p*PRF_IDX_W +: PRF_IDX_W]  = PRF_IDX_W'(tag);
    bus.cdb_rd_value[p*32 +: 32]              = val;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.flush = 1'b0;
    bus.fu_br_ready = 1'b1;
    bus.cdb_rd_phy = '0;
    bus.cdb_rd_value = '0;
    idle();
    applyStimulus(OP_BEQ, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 0, 1'b1, 32'h0);
    bus.disp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Out of reset: empty station.
    #1;
    checkOutput("reset_disp_ready", 32'(bus.disp_ready), 32'h1);
    checkOutput("reset_br_rs_valid", 32'(bus.br_rs_valid), 32'h0);

    // BEQ with both sources ready issues the next cycle.
    applyStimulus(OP_BEQ, 32'h100, 32'h20, 1, 1, 1'b1, 32'd5, 2, 1'b1, 32'd5);
    #1;
    checkOutput("beq_disp_cycle_valid", 32'(bus.br_rs_valid), 32'h0);
    tick();
    idle();
    #1;
    checkOutput("beq_valid", 32'(bus.br_rs_valid), 32'h1);
    checkOutput("beq_pc", bus.fu_br_reg_in.pc, 32'h100);
    checkOutput("beq_imm", bus.fu_br_reg_in.imm, 32'h20);
    checkOutput("beq_rs1", bus.fu_br_reg_in.rs1_value, 32'd5);
    checkOutput("beq_rs2", bus.fu_br_reg_in.rs2_value, 32'd5);
    tick();
    #1;
    checkOutput("beq_drained_valid", 32'(bus.br_rs_valid), 32'h0);

    // JALR waiting on tag 7, woken by cdb port 1.
    applyStimulus(OP_JALR, 32'h200, 32'h4, 2, 7, 1'b0, 32'h0, 0, 1'b1, 32'h0);
    tick();
    idle();
    #1;
    checkOutput("jalr_wait_valid", 32'(bus.br_rs_valid), 32'h0);
    tick();
    setCdb(1, 7, 32'h2000);
    #1;
    checkOutput("jalr_wake_cycle_valid", 32'(bus.br_rs_valid), 32'h0);
    tick();
    idle();
    #1;
    checkOutput("jalr_woken_valid", 32'(bus.br_rs_valid), 32'h1);
    checkOutput("jalr_rs1", bus.fu_br_reg_in.rs1_value, 32'h2000);
    checkOutput("jalr_opcode", 32'(bus.fu_br_reg_in.fu_opcode), 32'(OP_JALR));
    tick();

    // Dispatch coinciding with the broadcast: bypass.
    applyStimulus(OP_JALR, 32'h300, 32'h8, 3, 7, 1'b0, 32'h0, 0, 1'b1, 32'h0);
    setCdb(0, 7, 32'h3000);
    tick();
    idle();
    #1;
    checkOutput("bypass_valid", 32'(bus.br_rs_valid), 32'h1);
    checkOutput("bypass_rs1", bus.fu_br_reg_in.rs1_value, 32'h3000);
    checkOutput("bypass_pc", bus.fu_br_reg_in.pc, 32'h300);
    tick();

    // Oldest waits, younger ready one goes first; order kept after compaction.
    applyStimulus(OP_BNE, 32'h400, 32'h10, 4, 3, 1'b0, 32'h0, 4, 1'b1, 32'd9);
    tick();
    applyStimulus(OP_BLT, 32'h500, 32'h14, 5, 8, 1'b1, 32'd1, 9, 1'b1, 32'd2);
    tick();
    applyStimulus(OP_BGE, 32'h600, 32'h18, 6, 3, 1'b0, 32'h0, 10, 1'b1, 32'd7);
    #1;
    checkOutput("order_young_first", 32'(bus.fu_br_reg_in.rob_id), 32'd5);
    tick();
    idle();
    setCdb(0, 3, 32'h33);
    #1;
    checkOutput("order_none_ready", 32'(bus.br_rs_valid), 32'h0);
    tick();
    idle();
    #1;
    checkOutput("order_a_rob", 32'(bus.fu_br_reg_in.rob_id), 32'd4);
    checkOutput("order_a_rs1", bus.fu_br_reg_in.rs1_value, 32'h33);
    tick();
    #1;
    checkOutput("order_c_rob", 32'(bus.fu_br_reg_in.rob_id), 32'd6);
    checkOutput("order_c_rs2", bus.fu_br_reg_in.rs2_value, 32'd7);
    tick();

    // Two ports carrying the same tag: port 0's value is captured.
    applyStimulus(OP_AUIPC, 32'h700, 32'h1000, 7, 20, 1'b0, 32'h0, 0, 1'b1, 32'h0);
    tick();
    idle();
    setCdb(0, 20, 32'h111);
    setCdb(1, 20, 32'h222);
    tick();
    idle();
    #1;
    checkOutput("dualcdb_rs1", bus.fu_br_reg_in.rs1_value, 32'h111);
    tick();

    // Fill all four slots with waiting uops.
    applyStimulus(OP_BEQ, 32'h800, 32'h4, 8, 21, 1'b0, 32'h0, 0, 1'b1, 32'h0);
    tick();
    applyStimulus(OP_BNE, 32'h804, 32'h4, 9, 22, 1'b0, 32'h0, 0, 1'b1, 32'h0);
    tick();
    applyStimulus(OP_BLT, 32'h808, 32'h4, 10, 23, 1'b0, 32'h0, 0, 1'b1, 32'h0);
    tick();
    applyStimulus(OP_BGE, 32'h80c, 32'h4, 11, 24, 1'b0, 32'h0, 0, 1'b1, 32'h0);
    #1;
    checkOutput("fill_three_ready", 32'(bus.disp_ready), 32'h1);
    tick();
    applyStimulus(OP_BEQ, 32'h900, 32'h4, 12, 1, 1'b1, 32'h1, 2, 1'b1, 32'h2);
    #1;
    checkOutput("full_disp_ready", 32'(bus.disp_ready), 32'h0);
    tick();
    setCdb(0, 21, 32'hA0);
    #1;
    checkOutput("full_wake_disp_ready", 32'(bus.disp_ready), 32'h0);
    tick();
    bus.cdb_valid = '0;
    #1;
    checkOutput("full_issue_valid", 32'(bus.br_rs_valid), 32'h1);
    checkOutput("full_issue_rob", 32'(bus.fu_br_reg_in.rob_id), 32'd8);
    checkOutput("full_issue_rs1", bus.fu_br_reg_in.rs1_value, 32'hA0);
    checkOutput("full_issue_refuse", 32'(bus.disp_ready), 32'h0);
    tick();

    // Slot freed; now stall the FU with a ready entry.
    idle();
    bus.fu_br_ready = 1'b0;
    setCdb(0, 22, 32'hB1);
    #1;
    checkOutput("freed_disp_ready", 32'(bus.disp_ready), 32'h1);
    tick();
    idle();
    #1;
    checkOutput("stall_valid", 32'(bus.br_rs_valid), 32'h1);
    checkOutput("stall_rob", 32'(bus.fu_br_reg_in.rob_id), 32'd9);
    tick();
    #1;
    checkOutput("stall_hold_rob", 32'(bus.fu_br_reg_in.rob_id), 32'd9);
    checkOutput("stall_hold_rs1", bus.fu_br_reg_in.rs1_value, 32'hB1);
    tick();

    // Flush with three entries and a concurrent ready dispatch.
    bus.flush = 1'b1;
    bus.fu_br_ready = 1'b1;
    applyStimulus(OP_BEQ, 32'hA00, 32'h4, 13, 1, 1'b1, 32'h1, 2, 1'b1, 32'h2);
    #1;
    checkOutput("flush_cycle_valid", 32'(bus.br_rs_valid), 32'h0);
    tick();
    bus.flush = 1'b0;
    idle();
    setCdb(0, 23, 32'hC0);
    setCdb(1, 24, 32'hC1);
    #1;
    checkOutput("post_flush_valid", 32'(bus.br_rs_valid), 32'h0);
    checkOutput("post_flush_disp_ready", 32'(bus.disp_ready), 32'h1);
    tick();
    idle();
    #1;
    checkOutput("post_flush_empty1", 32'(bus.br_rs_valid), 32'h0);
    tick();
    #1;
    checkOutput("post_flush_empty2", 32'(bus.br_rs_valid), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
